tlb_op_ctrl: RTL and testbench



---
 rtl/tlb_op_ctrl_if.sv | 38 +++
 rtl/tlb_op_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl_if
//
// Pipeline-side handshake bundle for the TLB maintenance sequencer.
// The memory-stage pipeline is the master, the sequencer is the slave.
//
// Signals:
//   op_valid    master->slave  pipeline presents an operation
//   op_ready    slave->master  sequencer can accept (IDLE only)
//   op_code     master->slave  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
//   inv_op      master->slave  INVTLB op field
//   inv_asid    master->slave  INVTLB ASID operand
//   inv_vpn     master->slave  INVTLB VA[31:13] operand
//   done_valid  slave->master  operation complete
//   done_ready  master->slave  pipeline acknowledges completion
//   done_err    slave->master  illegal op_code or inv_op > 6
// ---------------------------------------------------------------------------
interface tlb_op_ctrl_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [18:0] inv_vpn;
  logic        done_valid;
  logic        done_ready;
  logic        done_err;

  modport master (
    output op_valid, op_code, inv_op, inv_asid, inv_vpn, done_ready,
    input  op_ready, done_valid, done_err
  );

  modport slave (
    input  op_valid, op_code, inv_op, inv_asid, inv_vpn, done_ready,
    output op_ready, done_valid, done_err
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl
//
// Sequencer for the TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB instructions.
// Accepts one operation at a time from the memory-stage pipeline, drives the
// translation unit's maintenance strobes, captures search/read results for
// the CSR file and reports completion with a valid/ready handshake.
//
// Optional feature macro: TLB_FILL_LFSR_EN
//   defined   : TLBFILL index comes from a free-running 5-bit LFSR
//   undefined : TLBFILL index is a round-robin counter
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   excp_flush, ertn_flush     abort the operation in progress
//   op_if                      pipeline handshake (slave modport)
//   tlb_wen                    TLBWR write strobe
//   tlb_fill_en, rand_index    TLBFILL write strobe and target index
//   tlbinv_en/op/asid/vpn      invalidate request
//   data_tlbserch_en           search request
//   serch_tlb_finish           search result valid
//   data_tlbfound/index        search hit and hit index
//   r_*                        read-port fields of the entry at TLBIDX
//   srch_we/found/index        CSR write pulse and data for search result
//   rd_we/e/vppn/asid/ps/elo*  CSR write pulse and data for read result
// ---------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter  int TLBNUM = 32,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             excp_flush,
  input  logic             ertn_flush,
  tlb_op_ctrl_if.slave     op_if,

  output logic             tlb_wen,
  output logic             tlb_fill_en,
  output logic [IDXW-1:0]  rand_index,

  output logic             tlbinv_en,
  output logic [4:0]       tlbinv_op,
  output logic [9:0]       tlbinv_asid,
  output logic [18:0]      tlbinv_vpn,

  output logic             data_tlbserch_en,
  input  logic             serch_tlb_finish,
  input  logic             data_tlbfound,
  input  logic [IDXW-1:0]  data_tlbindex,

  input  logic [18:0]      r_vppn,
  input  logic [9:0]       r_asid,
  input  logic             r_g,
  input  logic [5:0]       r_ps,
  input  logic             r_e,
  input  logic             r_v0,
  input  logic             r_v1,
  input  logic             r_d0,
  input  logic             r_d1,
  input  logic [1:0]       r_mat0,
  input  logic [1:0]       r_mat1,
  input  logic [1:0]       r_plv0,
  input  logic [1:0]       r_plv1,
  input  logic [19:0]      r_ppn0,
  input  logic [19:0]      r_ppn1,

  output logic             srch_we,
  output logic             srch_found,
  output logic [IDXW-1:0]  srch_index,

  output logic             rd_we,
  output logic             rd_e,
  output logic [18:0]      rd_vppn,
  output logic [9:0]       rd_asid,
  output logic [5:0]       rd_ps,
  output logic [31:0]      rd_elo0,
  output logic [31:0]      rd_elo1
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_INV,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      next_state;

  logic        flush;
  logic        accept;
  logic        op_illegal;
  logic [2:0]  op_q;
  logic        err_q;
  logic        first_done;
  logic [31:0] elo0_raw;
  logic [31:0] elo1_raw;

  assign flush  = excp_flush | ertn_flush;
  assign accept = (state == ST_IDLE) & op_if.op_valid & ~flush;

  // Unknown codes and INVTLB ops above 6 finish immediately with an error
  // and never reach the translation unit.
  assign op_illegal = (op_if.op_code > OP_INV) |
                      ((op_if.op_code == OP_INV) & (op_if.inv_op > 5'd6));

  // EntryLO layout: {4'b0, ppn, 1'b0, g, mat, plv, d, v}
  assign elo0_raw = {4'b0, r_ppn0, 1'b0, r_g, r_mat0, r_plv0, r_d0, r_v0};
  assign elo1_raw = {4'b0, r_ppn1, 1'b0, r_g, r_mat1, r_plv1, r_d1, r_v1};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a flush overrides every other transition
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_illegal) begin
            next_state = ST_DONE;
          end else begin
            case (op_if.op_code)
              OP_SRCH: next_state = ST_SRCH;
              OP_RD:   next_state = ST_RD;
              OP_WR:   next_state = ST_WR;
              OP_FILL: next_state = ST_FILL;
              default: next_state = ST_INV;
            endcase
          end
        end
      end
      ST_SRCH: begin
        if (serch_tlb_finish) begin
          next_state = ST_DONE;
        end
      end
      ST_RD, ST_WR, ST_FILL, ST_INV: next_state = ST_DONE;
      ST_DONE: begin
        if (op_if.done_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (flush) begin
      next_state = ST_IDLE;
    end
  end

  // Strobes and handshake outputs decode directly from the current state,
  // so a flush clears them the cycle after it is seen.
  always_comb begin
    op_if.op_ready   = 1'b0;
    op_if.done_valid = 1'b0;
    op_if.done_err   = 1'b0;
    data_tlbserch_en = 1'b0;
    tlb_wen          = 1'b0;
    tlb_fill_en      = 1'b0;
    tlbinv_en        = 1'b0;
    srch_we          = 1'b0;
    rd_we            = 1'b0;
    case (state)
      ST_IDLE: op_if.op_ready   = 1'b1;
      ST_SRCH: data_tlbserch_en = 1'b1;
      ST_WR:   tlb_wen          = 1'b1;
      ST_FILL: tlb_fill_en      = 1'b1;
      ST_INV:  tlbinv_en        = 1'b1;
      ST_DONE: begin
        op_if.done_valid = 1'b1;
        op_if.done_err   = err_q;
        srch_we          = first_done & ~err_q & (op_q == OP_SRCH);
        rd_we            = first_done & ~err_q & (op_q == OP_RD);
      end
      default: ;
    endcase
  end

  // Operation bookkeeping: code, error flag and INVTLB operands are held
  // from acceptance until the next acceptance. first_done marks only the
  // entry cycle of DONE so the CSR pulses fire once however long the
  // pipeline stalls done_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= 3'd0;
      err_q       <= 1'b0;
      tlbinv_op   <= 5'd0;
      tlbinv_asid <= 10'd0;
      tlbinv_vpn  <= 19'd0;
      first_done  <= 1'b0;
    end else begin
      first_done <= (next_state == ST_DONE) && (state != ST_DONE);
      if (accept) begin
        op_q        <= op_if.op_code;
        err_q       <= op_illegal;
        tlbinv_op   <= op_if.inv_op;
        tlbinv_asid <= op_if.inv_asid;
        tlbinv_vpn  <= op_if.inv_vpn;
      end
    end
  end

  // Search and read result capture. These registers only change in their
  // own operation state, so they stay stable while DONE waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      srch_found <= 1'b0;
      srch_index <= '0;
      rd_e       <= 1'b0;
      rd_vppn    <= 19'd0;
      rd_asid    <= 10'd0;
      rd_ps      <= 6'd0;
      rd_elo0    <= 32'd0;
      rd_elo1    <= 32'd0;
    end else begin
      if ((state == ST_SRCH) && serch_tlb_finish) begin
        srch_found <= data_tlbfound;
        srch_index <= data_tlbindex;
      end
      if (state == ST_RD) begin
        rd_e    <= r_e;
        rd_vppn <= r_e ? r_vppn   : 19'd0;
        rd_asid <= r_e ? r_asid   : 10'd0;
        rd_ps   <= r_e ? r_ps     : 6'd0;
        rd_elo0 <= r_e ? elo0_raw : 32'd0;
        rd_elo1 <= r_e ? elo1_raw : 32'd0;
      end
    end
  end

`ifdef TLB_FILL_LFSR_EN
  // Free-running maximal-length 5-bit LFSR; seeded non-zero so it never
  // locks up at 0. The fill index is a snapshot taken as FILL is entered,
  // so it cannot change under the strobe.
  logic [IDXW-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr       <= 5'b00001;
      rand_index <= 5'b00001;
    end else begin
      lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      if (accept && !op_illegal && (op_if.op_code == OP_FILL)) begin
        rand_index <= lfsr;
      end
    end
  end
`else
  // Round-robin fill victim: advances after each FILL strobe, wrapping
  // naturally at the index width.
  always_ff @(posedge clk) begin
    if (reset) begin
      rand_index <= '0;
    end else if (state == ST_FILL) begin
      rand_index <= rand_index + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlb_op_ctrl
//
// Directed-vector bench for tlb_op_ctrl. Stimulus pushes expected completion
// records and expected strobe records into queues; two monitor processes pop
// and compare whenever the DUT raises done_valid or a TLB strobe.
// Works with and without TLB_FILL_LFSR_EN.
// ---------------------------------------------------------------------------
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        excp_flush = 1'b0;
  logic        ertn_flush = 1'b0;

  logic        tlb_wen, tlb_fill_en, tlbinv_en, data_tlbserch_en;
  logic [4:0]  rand_index;
  logic [4:0]  tlbinv_op;
  logic [9:0]  tlbinv_asid;
  logic [18:0] tlbinv_vpn;
  logic        serch_tlb_finish = 1'b0;
  logic        data_tlbfound = 1'b0;
  logic [4:0]  data_tlbindex = 5'd0;

  logic [18:0] r_vppn = '0;
  logic [9:0]  r_asid = '0;
  logic        r_g = 1'b0;
  logic [5:0]  r_ps = '0;
  logic        r_e = 1'b0;
  logic        r_v0 = 1'b0, r_v1 = 1'b0, r_d0 = 1'b0, r_d1 = 1'b0;
  logic [1:0]  r_mat0 = '0, r_mat1 = '0, r_plv0 = '0, r_plv1 = '0;
  logic [19:0] r_ppn0 = '0, r_ppn1 = '0;

  logic        srch_we, srch_found, rd_we, rd_e;
  logic [4:0]  srch_index;
  logic [18:0] rd_vppn;
  logic [9:0]  rd_asid;
  logic [5:0]  rd_ps;
  logic [31:0] rd_elo0, rd_elo1;

  int checks = 0;
  int failures = 0;

  tlb_op_ctrl_if bus ();

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .excp_flush       (excp_flush),
    .ertn_flush       (ertn_flush),
    .op_if            (bus.slave),
    .tlb_wen          (tlb_wen),
    .tlb_fill_en      (tlb_fill_en),
    .rand_index       (rand_index),
    .tlbinv_en        (tlbinv_en),
    .tlbinv_op        (tlbinv_op),
    .tlbinv_asid      (tlbinv_asid),
    .tlbinv_vpn       (tlbinv_vpn),
    .data_tlbserch_en (data_tlbserch_en),
    .serch_tlb_finish (serch_tlb_finish),
    .data_tlbfound    (data_tlbfound),
    .data_tlbindex    (data_tlbindex),
    .r_vppn           (r_vppn),
    .r_asid           (r_asid),
    .r_g              (r_g),
    .r_ps             (r_ps),
    .r_e              (r_e),
    .r_v0             (r_v0),
    .r_v1             (r_v1),
    .r_d0             (r_d0),
    .r_d1             (r_d1),
    .r_mat0           (r_mat0),
    .r_mat1           (r_mat1),
    .r_plv0           (r_plv0),
    .r_plv1           (r_plv1),
    .r_ppn0           (r_ppn0),
    .r_ppn1           (r_ppn1),
    .srch_we          (srch_we),
    .srch_found       (srch_found),
    .srch_index       (srch_index),
    .rd_we            (rd_we),
    .rd_e             (rd_e),
    .rd_vppn          (rd_vppn),
    .rd_asid          (rd_asid),
    .rd_ps            (rd_ps),
    .rd_elo0          (rd_elo0),
    .rd_elo1          (rd_elo1)
  );

  typedef struct {
    logic        err;
    logic        is_srch;
    logic        is_rd;
    logic        found;
    logic [4:0]  index;
    logic        e;
    logic [18:0] vppn;
    logic [9:0]  asid;
    logic [5:0]  ps;
    logic [31:0] elo0;
    logic [31:0] elo1;
  } done_t;

  typedef struct {
    int          kind;
    logic [4:0]  index;
    logic [4:0]  op;
    logic [9:0]  asid;
    logic [18:0] vpn;
  } strobe_t;

  done_t   done_q[$];
  strobe_t strobe_q[$];

  // Reference LFSR for the fill index, advancing with the DUT from reset
  logic [4:0] lfsr_model;
  int         fill_count = 0;

  always @(posedge clk) begin
    if (reset) lfsr_model <= 5'b00001;
    else       lfsr_model <= {lfsr_model[3:0], lfsr_model[4] ^ lfsr_model[2]};
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic done_t mkDone(input logic err, input logic is_srch,
                                   input logic is_rd);
    done_t d;
    d.err = err; d.is_srch = is_srch; d.is_rd = is_rd;
    d.found = 1'b0; d.index = '0; d.e = 1'b0; d.vppn = '0; d.asid = '0;
    d.ps = '0; d.elo0 = '0; d.elo1 = '0;
    return d;
  endfunction

  // Waits for op_ready, presents one operation for one accepting edge and
  // queues the strobe it must produce. Returns one ns after the accepting
  // edge, i.e. inside cycle T+1.
  task automatic applyStimulus(input logic [2:0] code, input logic [4:0] iop,
                               input logic [9:0] asid, input logic [18:0] vpn);
    int      waitCnt = 0;
    strobe_t s;
    while (!bus.op_ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!bus.op_ready) begin
      checks++; failures++;
      $display("[TB] FAIL op_ready_timeout actual=0 required=1");
    end
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.inv_op   = iop;
    bus.inv_asid = asid;
    bus.inv_vpn  = vpn;
    s.kind = 0; s.index = '0; s.op = iop; s.asid = asid; s.vpn = vpn;
    if (code == 3'd2) begin
      s.kind = 1;
      strobe_q.push_back(s);
    end else if (code == 3'd3) begin
      s.kind = 2;
`ifdef TLB_FILL_LFSR_EN
      s.index = lfsr_model;
`else
      s.index = fill_count[4:0];
      fill_count++;
`endif
      strobe_q.push_back(s);
    end else if (code == 3'd4 && iop <= 5'd6) begin
      s.kind = 3;
      strobe_q.push_back(s);
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int cnt = 0;
    while ((done_q.size() != 0 || strobe_q.size() != 0 || !bus.op_ready)
           && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (cnt >= 100) begin
      checks++; failures++;
      $display("[TB] FAIL idle_timeout actual=done_q:%0d strobe_q:%0d required=0",
               done_q.size(), strobe_q.size());
    end
  endtask

  // Completion monitor: first DONE cycle pops and checks the record, later
  // DONE cycles check that pulses are gone and data is held.
  logic  holding = 1'b0;
  done_t cur;

  always @(negedge clk) begin
    if (!reset && bus.done_valid) begin
      if (!holding) begin
        if (done_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          cur = done_q.pop_front();
          holding = 1'b1;
          checkOutput("done_err", 32'(bus.done_err), 32'(cur.err));
          checkOutput("srch_we", 32'(srch_we), 32'(cur.is_srch));
          checkOutput("rd_we", 32'(rd_we), 32'(cur.is_rd));
          if (cur.is_srch) begin
            checkOutput("srch_found", 32'(srch_found), 32'(cur.found));
            checkOutput("srch_index", 32'(srch_index), 32'(cur.index));
          end
          if (cur.is_rd) begin
            checkOutput("rd_e", 32'(rd_e), 32'(cur.e));
            checkOutput("rd_vppn", 32'(rd_vppn), 32'(cur.vppn));
            checkOutput("rd_asid", 32'(rd_asid), 32'(cur.asid));
            checkOutput("rd_ps", 32'(rd_ps), 32'(cur.ps));
            checkOutput("rd_elo0", rd_elo0, cur.elo0);
            checkOutput("rd_elo1", rd_elo1, cur.elo1);
          end
        end
      end else begin
        checkOutput("srch_we_hold", 32'(srch_we), 32'd0);
        checkOutput("rd_we_hold", 32'(rd_we), 32'd0);
        checkOutput("done_err_hold", 32'(bus.done_err), 32'(cur.err));
        if (cur.is_rd) begin
          checkOutput("rd_elo0_hold", rd_elo0, cur.elo0);
          checkOutput("rd_vppn_hold", 32'(rd_vppn), 32'(cur.vppn));
        end
      end
      if (bus.done_ready) holding = 1'b0;
    end
  end

  // Strobe monitor: every cycle with a TLB strobe must match the next
  // queued strobe; a second cycle of the same strobe finds nothing queued.
  strobe_t exp_s;
  int      seen_kind;

  always @(negedge clk) begin
    if (!reset && (tlb_wen || tlb_fill_en || tlbinv_en)) begin
      seen_kind = tlb_wen ? 1 : (tlb_fill_en ? 2 : 3);
      checkOutput("strobe_onehot",
                  32'(tlb_wen) + 32'(tlb_fill_en) + 32'(tlbinv_en), 32'd1);
      if (strobe_q.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_strobe actual=kind%0d required=none",
                 seen_kind);
      end else begin
        exp_s = strobe_q.pop_front();
        checkOutput("strobe_kind", 32'(seen_kind), 32'(exp_s.kind));
        if (seen_kind == 2) begin
          checkOutput("fill_index", 32'(rand_index), 32'(exp_s.index));
`ifdef TLB_FILL_LFSR_EN
          checkOutput("fill_index_nonzero", 32'(rand_index != 5'd0), 32'd1);
`endif
        end
        if (seen_kind == 3) begin
          checkOutput("inv_op", 32'(tlbinv_op), 32'(exp_s.op));
          checkOutput("inv_asid", 32'(tlbinv_asid), 32'(exp_s.asid));
          checkOutput("inv_vpn", 32'(tlbinv_vpn), 32'(exp_s.vpn));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  done_t d;

  initial begin
    bus.op_valid   = 1'b0;
    bus.op_code    = 3'd0;
    bus.inv_op     = 5'd0;
    bus.inv_asid   = 10'd0;
    bus.inv_vpn    = 19'd0;
    bus.done_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_op_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("rst_done_valid", 32'(bus.done_valid), 32'd0);
    checkOutput("rst_done_err", 32'(bus.done_err), 32'd0);
    checkOutput("rst_tlb_wen", 32'(tlb_wen), 32'd0);
    checkOutput("rst_fill_en", 32'(tlb_fill_en), 32'd0);
    checkOutput("rst_inv_en", 32'(tlbinv_en), 32'd0);
    checkOutput("rst_srch_en", 32'(data_tlbserch_en), 32'd0);
    checkOutput("rst_srch_we", 32'(srch_we), 32'd0);
    checkOutput("rst_rd_we", 32'(rd_we), 32'd0);
    checkOutput("rst_rd_elo0", rd_elo0, 32'd0);
    checkOutput("rst_inv_vpn", 32'(tlbinv_vpn), 32'd0);
`ifdef TLB_FILL_LFSR_EN
    checkOutput("rst_rand_index", 32'(rand_index), 32'd1);
`else
    checkOutput("rst_rand_index", 32'(rand_index), 32'd0);
`endif
    @(posedge clk); #1;

    // TLBWR
    $display("[TB] TLBWR");
    done_q.push_back(mkDone(1'b0, 1'b0, 1'b0));
    applyStimulus(3'd2, 5'd0, 10'd0, 19'd0);
    @(negedge clk);
    checkOutput("wr_op_ready_busy", 32'(bus.op_ready), 32'd0);
    checkOutput("wr_done_early", 32'(bus.done_valid), 32'd0);
    @(posedge clk); #1;
    waitIdle();

    // TLBSRCH hit at index 7, finish at T+2
    $display("[TB] TLBSRCH hit");
    d = mkDone(1'b0, 1'b1, 1'b0); d.found = 1'b1; d.index = 5'd7;
    done_q.push_back(d);
    applyStimulus(3'd0, 5'd0, 10'd0, 19'd0);
    @(negedge clk);
    checkOutput("srch_en_t1", 32'(data_tlbserch_en), 32'd1);
    @(posedge clk); #1;
    serch_tlb_finish = 1'b1; data_tlbfound = 1'b1; data_tlbindex = 5'd7;
    @(negedge clk);
    checkOutput("srch_en_t2", 32'(data_tlbserch_en), 32'd1);
    @(posedge clk); #1;
    serch_tlb_finish = 1'b0; data_tlbfound = 1'b0; data_tlbindex = 5'd0;
    @(negedge clk);
    checkOutput("srch_en_t3", 32'(data_tlbserch_en), 32'd0);
    checkOutput("srch_done_t3", 32'(bus.done_valid), 32'd1);
    @(posedge clk); #1;
    waitIdle();

    // TLBSRCH miss with a late finish
    $display("[TB] TLBSRCH miss");
    d = mkDone(1'b0, 1'b1, 1'b0); d.found = 1'b0; d.index = 5'd12;
    done_q.push_back(d);
    applyStimulus(3'd0, 5'd0, 10'd0, 19'd0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("srch_en_wait", 32'(data_tlbserch_en), 32'd1);
    @(posedge clk); #1;
    serch_tlb_finish = 1'b1; data_tlbfound = 1'b0; data_tlbindex = 5'd12;
    @(posedge clk); #1;
    serch_tlb_finish = 1'b0; data_tlbindex = 5'd0;
    waitIdle();

    // TLBRD of an invalid entry: everything forced to zero
    $display("[TB] TLBRD e=0");
    r_e = 1'b0; r_vppn = 19'h7FFFF; r_asid = 10'h3FF; r_ps = 6'd21; r_g = 1'b1;
    r_v0 = 1'b1; r_d0 = 1'b1; r_ppn0 = 20'hFFFFF; r_ppn1 = 20'h11111;
    done_q.push_back(mkDone(1'b0, 1'b0, 1'b1));
    applyStimulus(3'd1, 5'd0, 10'd0, 19'd0);
    waitIdle();

    // TLBRD of a valid entry, with done_ready stalled to check stability
    $display("[TB] TLBRD e=1");
    r_e = 1'b1; r_vppn = 19'h5A5A5; r_asid = 10'h155; r_ps = 6'd12; r_g = 1'b0;
    r_ppn0 = 20'h12345; r_v0 = 1'b1; r_d0 = 1'b1; r_mat0 = 2'b00; r_plv0 = 2'b00;
    r_ppn1 = 20'hABCDE; r_v1 = 1'b1; r_d1 = 1'b0; r_mat1 = 2'b01; r_plv1 = 2'b11;
    d = mkDone(1'b0, 1'b0, 1'b1);
    d.e = 1'b1; d.vppn = 19'h5A5A5; d.asid = 10'h155; d.ps = 6'd12;
    d.elo0 = 32'h01234503; d.elo1 = 32'h0ABCDE1D;
    done_q.push_back(d);
    bus.done_ready = 1'b0;
    applyStimulus(3'd1, 5'd0, 10'd0, 19'd0);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("rd_stall_valid", 32'(bus.done_valid), 32'd1);
    checkOutput("rd_stall_op_ready", 32'(bus.op_ready), 32'd0);
    @(posedge clk); #1;
    bus.done_ready = 1'b1;
    waitIdle();

    // INVTLB with op 7: error, no strobe
    $display("[TB] INVTLB op=7");
    done_q.push_back(mkDone(1'b1, 1'b0, 1'b0));
    applyStimulus(3'd4, 5'd7, 10'h3FF, 19'h1ABCD);
    waitIdle();

    // INVTLB with op 5
    $display("[TB] INVTLB op=5");
    done_q.push_back(mkDone(1'b0, 1'b0, 1'b0));
    applyStimulus(3'd4, 5'd5, 10'h3FF, 19'h1ABCD);
    waitIdle();

    // Illegal op_code
    $display("[TB] illegal op_code");
    done_q.push_back(mkDone(1'b1, 1'b0, 1'b0));
    applyStimulus(3'd6, 5'd0, 10'd0, 19'd0);
    waitIdle();

    // excp_flush during SRCH before finish: no completion at all
    $display("[TB] flush in SRCH");
    applyStimulus(3'd0, 5'd0, 10'd0, 19'd0);
    excp_flush = 1'b1;
    @(posedge clk); #1;
    excp_flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_op_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("flush_srch_en", 32'(data_tlbserch_en), 32'd0);
    repeat (3) begin @(posedge clk); #1; end

    // op_valid together with ertn_flush is ignored
    $display("[TB] op_valid with flush");
    bus.op_valid = 1'b1; bus.op_code = 3'd2; ertn_flush = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; ertn_flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_accept_ready", 32'(bus.op_ready), 32'd1);
    checkOutput("flush_accept_wen", 32'(tlb_wen), 32'd0);
    @(posedge clk); #1;

    // Four back-to-back TLBFILLs
    $display("[TB] TLBFILL x4");
    for (int i = 0; i < 4; i++) begin
      done_q.push_back(mkDone(1'b0, 1'b0, 1'b0));
      applyStimulus(3'd3, 5'd0, 10'd0, 19'd0);
    end
    waitIdle();

    repeat (2) begin @(posedge clk); #1; end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
